serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: a bit-serial adder with a valid/ready request port and a
// valid/ready result port. One full_adder processes one operand bit per
// cycle, LSB first.
// Optional feature macro: SERIAL_ADDER_SUB_EN. It adds the i_sub port. When
// i_sub is 1, the block computes A-B, and o_carry=1 means no borrow.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// State table
//   S_IDLE | waiting for a request; o_ready high
//   S_RUN  | one operand bit per cycle through the full adder
//   S_DONE | result presented with o_valid; waits for i_ready
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_bit1,
  input  logic [WIDTH-1:0] i_bit2,
  input  logic             i_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_step;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_sub;

  logic             w_sub_in;
  logic             w_cin_load;
  logic             w_b_bit;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_sum_shift;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_sub_in = i_sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1, so the carry-in is forced to 1.
  assign w_cin_load = w_sub_in ? 1'b1 : i_cin;
  assign w_b_bit    = r_b[0] ^ r_sub;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (w_b_bit),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // Each new sum bit enters at the MSB, so after WIDTH steps bit 0 is at the LSB.
  assign w_sum_shift = (r_sum >> 1) | (WIDTH'(w_fa_s) << (WIDTH - 1));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    o_ready  = 1'b0;
    o_valid  = 1'b0;
    o_busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        w_step = 1'b1;
        if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on accept, then one bit per RUN cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sub   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_bit1;
      r_b     <= i_bit2;
      r_carry <= w_cin_load;
      r_cnt   <= '0;
      r_sub   <= w_sub_in;
    end else if (w_step) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= w_sum_shift;
      r_carry <= w_fa_c;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign o_sum   = r_sum;
  assign o_carry = r_carry;

endmodule
